// File: rtl/cpu_boot_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_boot_ctrl
//
// Boot sequencer for the single-accumulator CPU. Holds the CPU in reset,
// streams a program image from the host into the shared single-port memory,
// then releases the CPU for a programmable number of cycles. Owns the memory
// port mux between the loader and the CPU; CPU read data bypasses this block.
//
// Parameters
//   LOAD_BASE     first memory word address written by the loader
//
// Ports
//   clock         system clock, rising-edge active
//   reset         synchronous active-low reset
//   load_start    begin a load+run sequence (honoured only in IDLE)
//   load_len      words to load, latched on an accepted load_start
//   run_len       CPU cycle budget, 0 = run until abort, latched with load_len
//   abort         return to IDLE from any state, no done pulse
//   ld_valid      host word valid
//   ld_data       host word
//   ld_ready      loader accepts a word this cycle
//   cpu_reset     active-high reset to the CPU
//   cpu_address   CPU memory address
//   cpu_we        CPU write enable
//   cpu_data_out  CPU write data
//   mem_address   memory address
//   mem_we        memory write enable
//   mem_data      memory write data
//   busy          sequencer is not idle
//   running       CPU is released
//   done          one-cycle pulse when the run budget expires
//   cycles_run    RUN cycles elapsed, saturating; held until the next start
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | CPU held in reset, waiting for load_start
// LOAD  | accepting host words, writing them from LOAD_BASE upward
// RUN   | CPU released, memory port owned by the CPU
// DONE  | budget expired, one-cycle done pulse, CPU back in reset
// ---------------------------------------------------------------------------
module cpu_boot_ctrl #(
    parameter logic [15:0] LOAD_BASE = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_start,
    input  logic [15:0] load_len,
    input  logic [31:0] run_len,
    input  logic        abort,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    output logic        cpu_reset,
    input  logic [15:0] cpu_address,
    input  logic        cpu_we,
    input  logic [31:0] cpu_data_out,
    output logic [15:0] mem_address,
    output logic        mem_we,
    output logic [31:0] mem_data,
    output logic        busy,
    output logic        running,
    output logic        done,
    output logic [31:0] cycles_run
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] pointer;
    logic [15:0] remaining;
    logic [31:0] run_left;
    logic [31:0] cycle_count;

    logic        start_ok;
    logic        xfer;
    logic        last_word;
    logic        budget_hit;

    assign start_ok  = (state == ST_IDLE) && load_start && !abort;
    assign xfer      = (state == ST_LOAD) && ld_valid;
    assign last_word = xfer && (remaining == 16'd1);

    // run_left is loaded with run_len and counts down once per RUN cycle.
    // A zero budget loads 0, which never reaches the terminal count of 1,
    // so the CPU runs until abort without needing a separate mode flag.
    assign budget_hit = (state == ST_RUN) && (run_left == 32'd1);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic; abort overrides completion and budget expiry
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_next = (load_len != 16'd0) ? ST_LOAD : ST_RUN;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (last_word) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (budget_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode, including the memory port mux
    // -----------------------------------------------------------------------
    always_comb begin
        ld_ready    = 1'b0;
        cpu_reset   = 1'b1;
        busy        = (state != ST_IDLE);
        running     = 1'b0;
        done        = 1'b0;
        mem_address = pointer;
        mem_we      = 1'b0;
        mem_data    = 32'd0;
        case (state)
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (xfer) begin
                    mem_we   = 1'b1;
                    mem_data = ld_data;
                end
            end
            ST_RUN: begin
                cpu_reset   = 1'b0;
                running     = 1'b1;
                mem_address = cpu_address;
                mem_we      = cpu_we;
                mem_data    = cpu_data_out;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign cycles_run = cycle_count;

    // -----------------------------------------------------------------------
    // Loader pointer, word count, run budget and cycle counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            pointer     <= LOAD_BASE;
            remaining   <= 16'd0;
            run_left    <= 32'd0;
            cycle_count <= 32'd0;
        end else begin
            if (start_ok) begin
                pointer     <= LOAD_BASE;
                remaining   <= load_len;
                run_left    <= run_len;
                cycle_count <= 32'd0;
            end
            if (xfer) begin
                // 16-bit add wraps 0xFFFF -> 0x0000 naturally
                pointer   <= pointer + 16'd1;
                remaining <= remaining - 16'd1;
            end
            if (state == ST_RUN) begin
                if (cycle_count != 32'hFFFF_FFFF) begin
                    cycle_count <= cycle_count + 32'd1;
                end
                if (run_left != 32'd0) begin
                    run_left <= run_left - 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_boot_ctrl
//
// Bench for cpu_boot_ctrl. Two instances share all inputs: one with
// LOAD_BASE = 0x0000 and one with LOAD_BASE = 0xFFFF so address wrap is
// exercised on every multi-word load. Each load+run sequence is scored at
// transaction level: the expected write list is (base + i, word[i]) for the
// words actually handed over, the CPU must be released for exactly run_len
// cycles, and done must pulse once only when a nonzero budget expires.
// ---------------------------------------------------------------------------
module tb_cpu_boot_ctrl;

    localparam logic [15:0] BASE_A = 16'h0000;
    localparam logic [15:0] BASE_B = 16'hFFFF;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_start;
    logic [15:0] load_len;
    logic [31:0] run_len;
    logic        abort;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [15:0] cpu_address;
    logic        cpu_we;
    logic [31:0] cpu_data_out;

    logic        ld_ready_a, cpu_reset_a, mem_we_a, busy_a, running_a, done_a;
    logic [15:0] mem_address_a;
    logic [31:0] mem_data_a, cycles_run_a;
    logic        ld_ready_b, cpu_reset_b, mem_we_b, busy_b, running_b, done_b;
    logic [15:0] mem_address_b;
    logic [31:0] mem_data_b, cycles_run_b;

    always #5 clock = ~clock;

    cpu_boot_ctrl #(.LOAD_BASE(BASE_A)) dut_a (
        .clock(clock), .reset(reset), .load_start(load_start),
        .load_len(load_len), .run_len(run_len), .abort(abort),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_a),
        .cpu_reset(cpu_reset_a), .cpu_address(cpu_address), .cpu_we(cpu_we),
        .cpu_data_out(cpu_data_out), .mem_address(mem_address_a),
        .mem_we(mem_we_a), .mem_data(mem_data_a), .busy(busy_a),
        .running(running_a), .done(done_a), .cycles_run(cycles_run_a)
    );

    cpu_boot_ctrl #(.LOAD_BASE(BASE_B)) dut_b (
        .clock(clock), .reset(reset), .load_start(load_start),
        .load_len(load_len), .run_len(run_len), .abort(abort),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready_b),
        .cpu_reset(cpu_reset_b), .cpu_address(cpu_address), .cpu_we(cpu_we),
        .cpu_data_out(cpu_data_out), .mem_address(mem_address_b),
        .mem_we(mem_we_b), .mem_data(mem_data_b), .busy(busy_b),
        .running(running_b), .done(done_b), .cycles_run(cycles_run_b)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t wr_a[$];
    wr_t wr_b[$];
    int  done_seen;
    bit  mon_en;

    int  n_checks;
    int  n_errors;

    // Memory write and done-pulse monitor, sampled mid-cycle
    always @(negedge clock) begin
        if (mon_en && mem_we_a) wr_a.push_back({mem_address_a, mem_data_a});
        if (mon_en && mem_we_b) wr_b.push_back({mem_address_b, mem_data_b});
        if (done_a) done_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One load+run sequence.
    //   nw        words to load
    //   rl        run budget (0 = run until the bench aborts)
    //   abort_w   abort once this many words were transferred (-1 = never)
    //   cpu_wr    issue one CPU write in the first RUN cycle
    //   all_valid hold ld_valid high instead of random gaps
    task automatic run_seq(input int nw, input int rl, input int abort_w,
                           input bit cpu_wr, input bit all_valid);
        logic [31:0] words[$];
        int sent, cyc, run_cnt, kstop, lim, wa0, wb0, d0, nexp;
        logic [15:0] ea, eb;

        chk("idle_busy", busy_a, 1'b0);
        chk("idle_cpu_reset", cpu_reset_a, 1'b1);

        for (int i = 0; i < nw; i++) words.push_back($urandom);
        wa0 = wr_a.size();
        wb0 = wr_b.size();
        d0  = done_seen;
        mon_en = 1'b1;

        load_start = 1'b1;
        load_len   = 16'(nw);
        run_len    = 32'(rl);
        step();
        load_start = 1'b0;
        load_len   = 16'($urandom);   // must not be re-sampled
        run_len    = $urandom;

        sent = 0;
        cyc  = 0;
        while (sent < nw && cyc < 1000) begin
            if (abort_w >= 0 && sent == abort_w) break;
            ld_valid = all_valid ? 1'b1 : ($urandom_range(0, 2) != 0);
            ld_data  = ld_valid ? words[sent] : $urandom;
            #1;
            chk("load_ready", ld_ready_a, 1'b1);
            if (ld_valid) sent++;
            step();
            cyc++;
        end
        ld_valid = 1'b0;

        if (abort_w >= 0) begin
            abort = 1'b1;
            #1;
            chk("abort_ready_before", ld_ready_a, 1'b1);
            step();
            abort    = 1'b0;
            ld_valid = 1'b1;
            ld_data  = $urandom;
            #1;
            chk("abort_ready", ld_ready_a, 1'b0);
            chk("abort_busy", busy_a, 1'b0);
            chk("abort_cpu_reset", cpu_reset_a, 1'b1);
            step();
            step();
            ld_valid = 1'b0;
            nexp = abort_w;
        end else begin
            #1;
            mon_en = 1'b0;
            chk("run_entry_running", running_a, 1'b1);
            chk("run_entry_cpu_reset", cpu_reset_a, 1'b0);
            chk("run_entry_ready", ld_ready_a, 1'b0);
            kstop = $urandom_range(4, 15);
            lim   = (rl == 0) ? kstop : rl + 5;
            run_cnt = 0;
            for (int k = 0; k < lim; k++) begin
                if (k != 0) #1;
                if (!running_a) break;
                if (k == 0 && cpu_wr) begin
                    cpu_we       = 1'b1;
                    cpu_address  = 16'h0020;
                    cpu_data_out = 32'hDEADBEEF;
                    #1;
                    chk("cpu_mem_we", mem_we_a, 1'b1);
                    chk("cpu_mem_addr", mem_address_a, 16'h0020);
                    chk("cpu_mem_data", mem_data_a, 32'hDEADBEEF);
                    chk("cpu_mem_addr_b", mem_address_b, 16'h0020);
                end
                load_start = (k == 2);   // ignored outside IDLE
                run_cnt++;
                step();
                cpu_we     = 1'b0;
                load_start = 1'b0;
            end
            if (rl == 0) begin
                #1;
                chk("free_running", running_a, 1'b1);
                chk("free_cycles", cycles_run_a, 32'(kstop));
                abort = 1'b1;
                step();
                abort = 1'b0;
                #1;
                chk("free_abort_busy", busy_a, 1'b0);
                chk("free_abort_cycles", cycles_run_a, 32'(kstop + 1));
                chk("free_no_done", done_seen - d0, 0);
            end else begin
                chk("budget_run_cycles", run_cnt, rl);
                chk("done_pulse", done_a, 1'b1);
                chk("done_cpu_reset", cpu_reset_a, 1'b1);
                chk("done_busy", busy_a, 1'b1);
                chk("done_mem_we", mem_we_a, 1'b0);
                chk("done_cycles", cycles_run_a, 32'(rl));
                step();
                #1;
                chk("after_done", done_a, 1'b0);
                chk("after_done_busy", busy_a, 1'b0);
                chk("after_done_cycles", cycles_run_a, 32'(rl));
                chk("done_count", done_seen - d0, 1);
            end
            nexp = nw;
        end
        mon_en = 1'b0;

        chk("write_count_a", wr_a.size() - wa0, nexp);
        chk("write_count_b", wr_b.size() - wb0, nexp);
        for (int i = 0; i < nexp; i++) begin
            ea = 16'(BASE_A + 16'(i));
            eb = 16'(BASE_B + 16'(i));
            if (wa0 + i < wr_a.size()) begin
                chk("write_addr_a", wr_a[wa0 + i].a, ea);
                chk("write_data_a", wr_a[wa0 + i].d, words[i]);
            end
            if (wb0 + i < wr_b.size()) begin
                chk("write_addr_b", wr_b[wb0 + i].a, eb);
                chk("write_data_b", wr_b[wb0 + i].d, words[i]);
            end
        end
    endtask

    initial begin
        int nw, rl, aw;
        n_checks     = 0;
        n_errors     = 0;
        mon_en       = 1'b0;
        reset        = 1'b0;
        load_start   = 1'b0;
        load_len     = 16'd0;
        run_len      = 32'd0;
        abort        = 1'b0;
        ld_valid     = 1'b0;
        ld_data      = 32'd0;
        cpu_address  = 16'd0;
        cpu_we       = 1'b0;
        cpu_data_out = 32'd0;

        step();
        step();
        chk("rst_cpu_reset", cpu_reset_a, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_running", running_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_ready", ld_ready_a, 1'b0);
        chk("rst_mem_we", mem_we_a, 1'b0);
        chk("rst_cycles", cycles_run_a, 32'd0);
        chk("rst_ptr_a", mem_address_a, BASE_A);
        chk("rst_ptr_b", mem_address_b, BASE_B);
        chk("rst_mem_data", mem_data_a, 32'd0);
        reset = 1'b1;
        step();

        run_seq(3, 0, -1, 1'b0, 1'b1);
        run_seq(3, 0, -1, 1'b0, 1'b0);
        run_seq(1, 10, -1, 1'b1, 1'b0);
        run_seq(4, 0, 2, 1'b0, 1'b0);
        run_seq(2, 5, -1, 1'b0, 1'b1);

        // load_start together with abort in IDLE is not accepted
        load_start = 1'b1;
        abort      = 1'b1;
        load_len   = 16'd3;
        step();
        load_start = 1'b0;
        abort      = 1'b0;
        #1;
        chk("start_abort_busy", busy_a, 1'b0);
        chk("start_abort_ready", ld_ready_a, 1'b0);

        run_seq(0, 3, -1, 1'b0, 1'b0);
        run_seq(2, 1, -1, 1'b1, 1'b0);

        // Reset pulse in the middle of a run
        load_start = 1'b1;
        load_len   = 16'd0;
        run_len    = 32'd0;
        step();
        load_start = 1'b0;
        step();
        step();
        step();
        #1;
        chk("midrun_running", running_a, 1'b1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("midrun_rst_cpu_reset", cpu_reset_a, 1'b1);
        chk("midrun_rst_running", running_a, 1'b0);
        chk("midrun_rst_busy", busy_a, 1'b0);
        chk("midrun_rst_cycles", cycles_run_a, 32'd0);
        chk("midrun_rst_ptr_b", mem_address_b, BASE_B);
        step();

        for (int t = 0; t < 20; t++) begin
            nw = $urandom_range(0, 6);
            rl = $urandom_range(0, 25);
            aw = (nw > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, nw - 1) : -1;
            run_seq(nw, rl, aw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cpu_boot_ctrl.md
Name: cpu_boot_ctrl

Overview:
- Sequences the single-accumulator CPU through three phases: hold in reset, load a program image into the shared single-port memory from a host word stream, then run for a programmable cycle budget.
- Owns the memory port mux between loader and CPU.
- Sits between the host interface, the CPU and the memory.
- CPU read data goes straight from memory to the CPU and does not pass through this block.

Parameters:
- LOAD_BASE, 16'h0000, first memory word address written by the loader.

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset; sampled on posedge clock
- load_start  in  1  begin a load+run sequence; honoured only in IDLE
- load_len  in  16  number of words to load; latched on accepted load_start
- run_len  in  32  CPU run budget in cycles; 0 = run until abort; latched with load_len
- abort  in  1  return to IDLE from any state
- ld_valid  in  1  host word valid
- ld_data  in  32  host word
- ld_ready  out  1  loader accepts word this cycle
- cpu_reset  out  1  active-high reset to CPU
- cpu_address  in  16  CPU memory address
- cpu_we  in  1  CPU write enable
- cpu_data_out  in  32  CPU write data
- mem_address  out  16  memory address
- mem_we  out  1  memory write enable
- mem_data  out  32  memory write data
- busy  out  1  state != IDLE
- running  out  1  state == RUN
- done  out  1  one-cycle pulse when run budget expires
- cycles_run  out  32  RUN cycles elapsed; holds after DONE/abort until next accepted load_start

Behaviour:
- Reset: any posedge with reset==0 forces:
  - state IDLE; cpu_reset=1; ld_ready=0; mem_we=0; busy=0; running=0; done=0; cycles_run=0.
  - Internal write pointer = LOAD_BASE; remaining count = 0.
  - This applies mid-LOAD or mid-RUN as well. Memory contents are left as written.
- States: IDLE, LOAD, RUN, DONE. cpu_reset = (state != RUN), decoded from the registered state.
- IDLE:
  - On load_start=1 and abort=0: latch load_len and run_len, clear cycles_run, set pointer=LOAD_BASE.
  - Next state is LOAD if load_len != 0, else RUN.
  - If load_start and abort are both 1, abort wins and the block stays in IDLE.
- LOAD:
  - ld_ready=1 (combinational from state).
  - Transfer cycle = ld_valid & ld_ready. In that same cycle: mem_we=1, mem_address=pointer, mem_data=ld_data.
  - After each transfer: pointer+1, wrapping modulo 2^16 (0xFFFF -> 0x0000); remaining-1.
  - Transfer of the last word sets next state to RUN.
  - Cycles with ld_valid=0 perform no write.
- RUN:
  - mem_address=cpu_address, mem_we=cpu_we, mem_data=cpu_data_out, passed through combinationally.
  - cycles_run increments every RUN cycle and saturates at 0xFFFFFFFF.
  - If run_len != 0 and cycles_run == run_len-1, next state is DONE. The CPU therefore sees exactly run_len rising edges with cpu_reset=0.
- DONE: lasts one cycle with done=1, cpu_reset=1, mem_we=0; then IDLE.
- Memory port outside LOAD transfer cycles and RUN: mem_we=0, mem_address=pointer, mem_data=0.
- abort=1 in LOAD, RUN or DONE: next state IDLE, no done pulse. abort has priority over load completion and budget expiry in the same cycle.
- load_start outside IDLE is ignored.
- Inputs load_len and run_len are sampled only on an accepted load_start.

Test Plan:
- LOAD_BASE=0, load_len=3, run_len=0; words 0x40000005, 0x10000010, 0x70000020 with ld_valid held high:
  - mem_we high 3 consecutive cycles at mem_address 0,1,2.
  - ld_ready low afterwards; running=1 and cpu_reset=0 on the next cycle.
- Same load with ld_valid gaps (1,0,0,1,0,1): exactly 3 writes, at addresses 0,1,2, only on valid cycles; no write during gaps.
- load_len=1, run_len=10:
  - running high exactly 10 cycles; done pulses 1 cycle; cycles_run=10.
  - cpu_reset=1 from the DONE cycle onward; busy falls the cycle after done.
- During RUN, drive cpu_we=1, cpu_address=0x0020, cpu_data_out=0xDEADBEEF: mem_we=1, mem_address=0x0020, mem_data=0xDEADBEEF in the same cycle.
- Abort and restart:
  - Assert abort after 2 of 4 words: IDLE next cycle, ld_ready=0, no further writes.
  - A new load_start restarts writing at LOAD_BASE.
  - load_start+abort together in IDLE: stays IDLE.
- Reset and wrap:
  - reset=0 for one cycle mid-RUN: next cycle cpu_reset=1, running=0, busy=0, cycles_run=0.
  - With LOAD_BASE=16'hFFFF and load_len=2: writes land at 0xFFFF then 0x0000.
